histogram_accumulator: RTL and testbench



---
 rtl/histogram_accumulator.sv | 214 +++++++++++++++++++++
 tb/tb_histogram_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// -----------------------------------------------------------------------------
// histogram_accumulator
//
// 256-bin saturating histogram. Each rising edge of Memory_add performs a
// read-modify-write on the bin selected by Addr. A request/valid readout port
// streams bins to the host, and clear_req zeroes the whole histogram between
// acquisitions. All memory traffic shares one synchronous read/write port.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset; starts an INIT sweep
//   Addr        bin address, sampled on a Memory_add rising edge
//   Memory_add  increment strobe; only its rising edge counts
//   rd_req      readout request, held high until rd_valid
//   rd_addr     bin to read, stable while rd_req is high
//   rd_data     bin value, meaningful while rd_valid is high
//   rd_valid    one-cycle pulse completing a read
//   clear_req   one-cycle pulse, starts a full clear (honoured only in IDLE)
//   busy        high during INIT and CLEAR sweeps
//   sat_flag    sticky: some bin hit all-ones; cleared by reset or clear
//   drop_count  saturating count of lost events; cleared by reset or clear
//
// Readout handshake: the requester raises rd_req with a stable rd_addr and
// keeps both until it sees rd_valid high for one cycle (rd_data is valid in
// that same cycle). It must drop rd_req before the FSM returns to IDLE,
// which happens one cycle after the rd_valid pulse; otherwise a second read
// of the same bin is started. Pending increments are always served before a
// readout, so the requester may wait arbitrarily long.
// -----------------------------------------------------------------------------
module histogram_accumulator #(
  parameter int COUNT_W = 16,
  parameter int DROP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         Addr,
  input  logic               Memory_add,
  input  logic               rd_req,
  input  logic [7:0]         rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               clear_req,
  output logic               busy,
  output logic               sat_flag,
  output logic [DROP_W-1:0]  drop_count
);

  localparam logic [2:0] S_INIT       = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_INC_RD     = 3'd2;
  localparam logic [2:0] S_INC_WR     = 3'd3;
  localparam logic [2:0] S_RDOUT      = 3'd4;
  localparam logic [2:0] S_RDOUT_DONE = 3'd5;
  localparam logic [2:0] S_CLEAR      = 3'd6;

  // FSM state; fsm_state is the name checkers bind to.
  logic [2:0] fsm_state;
  logic [2:0] state_nxt;

  logic [7:0] sweep_addr;
  logic       add_d;
  logic       pend_valid;
  logic [7:0] pend_addr;
  logic [7:0] inc_addr;

  // Single-port histogram memory and its registered read data.
  logic [COUNT_W-1:0] mem [256];
  logic [COUNT_W-1:0] q;

  logic               mem_en;
  logic               mem_we;
  logic [7:0]         mem_addr;
  logic [COUNT_W-1:0] mem_wdata;

  // Event classification.
  logic edge_evt;
  logic sweeping;
  logic drop_evt;
  logic accept_evt;

  // IDLE decisions.
  logic take_pend;
  logic start_clear;
  logic start_read;

  // Saturating increment.
  logic [COUNT_W:0]   inc_sum;
  logic               q_max;
  logic [COUNT_W-1:0] inc_val;

  assign edge_evt   = Memory_add & ~add_d;
  assign sweeping   = (fsm_state == S_INIT) || (fsm_state == S_CLEAR);
  assign drop_evt   = edge_evt & (pend_valid | sweeping);
  assign accept_evt = edge_evt & ~drop_evt;
  assign busy       = sweeping;

  assign take_pend   = (fsm_state == S_IDLE) && pend_valid;
  assign start_clear = (fsm_state == S_IDLE) && !pend_valid && clear_req;
  // An edge arriving this very cycle will be pending next cycle, so the
  // readout is held back to let that increment land first.
  assign start_read  = (fsm_state == S_IDLE) && !pend_valid && !clear_req &&
                       rd_req && !edge_evt;

  // The carry out of the widened sum is set exactly when q is all-ones.
  assign inc_sum = {1'b0, q} + {{COUNT_W{1'b0}}, 1'b1};
  assign q_max   = inc_sum[COUNT_W];
  assign inc_val = q_max ? q : inc_sum[COUNT_W-1:0];

  // Memory port arbitration: the FSM state alone decides who owns the port.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = '0;
    case (fsm_state)
      S_INIT, S_CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = sweep_addr;
      end
      S_IDLE: begin
        if (pend_valid) begin
          mem_en   = 1'b1;
          mem_addr = pend_addr;
        end else if (start_read) begin
          mem_en   = 1'b1;
          mem_addr = rd_addr;
        end
      end
      S_INC_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = inc_addr;
        mem_wdata = inc_val;
      end
      default: ;
    endcase
  end

  // Next-state logic. IDLE priority: pending increment, clear, readout.
  always_comb begin
    state_nxt = fsm_state;
    case (fsm_state)
      S_INIT, S_CLEAR: begin
        if (sweep_addr == 8'hFF) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (take_pend)        state_nxt = S_INC_RD;
        else if (start_clear) state_nxt = S_CLEAR;
        else if (start_read)  state_nxt = S_RDOUT;
      end
      S_INC_RD:     state_nxt = S_INC_WR;
      S_INC_WR:     state_nxt = S_IDLE;
      S_RDOUT:      state_nxt = S_RDOUT_DONE;
      S_RDOUT_DONE: state_nxt = S_IDLE;
      default:      state_nxt = S_INIT;
    endcase
  end

  // Histogram storage: synchronous read with one cycle of latency. It has no
  // reset of its own; the INIT sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        q <= mem[mem_addr];
    end
  end

  // Control, event buffer, readout and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state  <= S_INIT;
      sweep_addr <= 8'd0;
      add_d      <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= 8'd0;
      inc_addr   <= 8'd0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      sat_flag   <= 1'b0;
      drop_count <= '0;
    end else begin
      fsm_state <= state_nxt;
      add_d     <= Memory_add;

      // The sweep counter wraps 255 -> 0, so it is ready for the next CLEAR.
      if (start_clear)   sweep_addr <= 8'd0;
      else if (sweeping) sweep_addr <= sweep_addr + 8'd1;

      // accept_evt implies pend_valid is clear, so it never collides with
      // take_pend in the same cycle.
      if (take_pend) begin
        pend_valid <= 1'b0;
        inc_addr   <= pend_addr;
      end
      if (accept_evt) begin
        pend_valid <= 1'b1;
        pend_addr  <= Addr;
      end

      rd_valid <= (fsm_state == S_RDOUT);
      if (fsm_state == S_RDOUT) rd_data <= q;

      if (start_clear)                           sat_flag <= 1'b0;
      else if ((fsm_state == S_INC_WR) && q_max) sat_flag <= 1'b1;

      if (start_clear)
        drop_count <= '0;
      else if (drop_evt && (drop_count != {DROP_W{1'b1}}))
        drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// -----------------------------------------------------------------------------
// tb_histogram_accumulator
//
// Directed bench for histogram_accumulator, run with small widths
// (COUNT_W=4, DROP_W=3) so bin and drop-counter saturation are reachable in
// a few hundred cycles. A table of strobe/read vectors covers the basic
// increment path; hand-written sequences cover read/strobe collision,
// saturation, drops during CLEAR and while an event is pending, and reset
// in the middle of an increment.
// -----------------------------------------------------------------------------
module tb_histogram_accumulator;

  localparam int CW = 4;
  localparam int DW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    Addr;
  logic          Memory_add;
  logic          rd_req;
  logic [7:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_req;
  logic          busy;
  logic          sat_flag;
  logic [DW-1:0] drop_count;

  always #5 clk = ~clk;

  histogram_accumulator #(.COUNT_W(CW), .DROP_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .Memory_add (Memory_add),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear_req  (clear_req),
    .busy       (busy),
    .sat_flag   (sat_flag),
    .drop_count (drop_count)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            last_lat = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] a, input int hi, input int lo);
    Addr       = a;
    Memory_add = 1'b1;
    repeat (hi) tick();
    Memory_add = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_read(input logic [7:0] a, input int exp);
    int n;
    logic [CW-1:0] e;
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(CW'(exp));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_valid && n < 40);
    last_lat = n;
    e = exp_q.pop_front();
    if (!rd_valid) check($sformatf("rd_timeout[%0d]", a), rd_valid, 1);
    else           check($sformatf("rd[%0d]", a), rd_data, e);
    rd_req = 1'b0;
    tick();
  endtask

  task automatic clear_pulse();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Waits out a reset-triggered INIT sweep: busy must still be high after
  // 255 edges and low after the 256th. Called with rst_n low, at a negedge.
  task automatic release_and_sweep(input string name);
    rst_n = 1'b1;
    repeat (255) @(posedge clk);
    @(negedge clk);
    check({name, "_busy_255"}, busy, 1);
    @(posedge clk);
    #1;
    check({name, "_busy_256"}, busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         is_read;
    logic [7:0] addr;
    int         exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 8'd0,   0};
    vecs[1] = '{1'b1, 8'd128, 0};
    vecs[2] = '{1'b1, 8'd255, 0};
    vecs[3] = '{1'b0, 8'd128, 0};
    vecs[4] = '{1'b0, 8'd135, 0};
    vecs[5] = '{1'b0, 8'd128, 0};
    vecs[6] = '{1'b1, 8'd128, 2};
    vecs[7] = '{1'b1, 8'd135, 1};
    vecs[8] = '{1'b1, 8'd0,   0};

    rst_n      = 1'b0;
    Addr       = 8'd0;
    Memory_add = 1'b0;
    rd_req     = 1'b0;
    rd_addr    = 8'd0;
    clear_req  = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     busy,       1);
    check("rst_rd_valid", rd_valid,   0);
    check("rst_rd_data",  rd_data,    0);
    check("rst_sat",      sat_flag,   0);
    check("rst_drop",     drop_count, 0);
    release_and_sweep("init");

    // Table: empty reads, three increments, read-back.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_read) do_read(vecs[i].addr, vecs[i].exp);
      else                 strobe(vecs[i].addr, 6, 2);
    end
    check("rd_latency_idle", last_lat, 3);
    check("basic_drop", drop_count, 0);
    check("basic_sat",  sat_flag,   0);

    // Read request and strobe edge in the same cycle: increment wins.
    rd_addr    = 8'd128;
    rd_req     = 1'b1;
    Addr       = 8'd128;
    Memory_add = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 6) Memory_add = 1'b0;
    end while (!rd_valid && n < 40);
    Memory_add = 1'b0;
    check("coll_valid",   rd_valid, 1);
    check("coll_data",    rd_data,  3);
    check("coll_latency", n,        7);
    rd_req = 1'b0;
    tick();
    check("coll_pulse_end", rd_valid, 0);
    tick();

    // Saturation of bin 121 (max = 15 at CW = 4).
    repeat (14) strobe(8'd121, 6, 2);
    do_read(8'd121, 14);
    check("sat_before", sat_flag, 0);
    repeat (2) strobe(8'd121, 6, 2);
    do_read(8'd121, 15);
    check("sat_after", sat_flag, 1);
    strobe(8'd121, 6, 2);
    do_read(8'd121, 15);

    // Clear: drop during the sweep, then a third edge while one is pending.
    clear_pulse();
    check("clr_busy", busy,       1);
    check("clr_sat",  sat_flag,   0);
    check("clr_drop", drop_count, 0);
    strobe(8'd50, 2, 2);
    check("clr_drop_sweep", drop_count, 1);
    wait_not_busy("clr_done");
    Addr = 8'd10; Memory_add = 1'b1; tick();
    Memory_add = 1'b0; tick();
    Addr = 8'd11; Memory_add = 1'b1; tick();
    Memory_add = 1'b0; tick();
    Addr = 8'd12; Memory_add = 1'b1; tick();
    Memory_add = 1'b0;
    repeat (6) tick();
    check("pend_drop", drop_count, 2);
    do_read(8'd10,  1);
    do_read(8'd11,  1);
    do_read(8'd12,  0);
    do_read(8'd50,  0);
    do_read(8'd128, 0);
    do_read(8'd121, 0);

    // Drop counter saturates at 7.
    clear_pulse();
    repeat (9) strobe(8'd60, 1, 1);
    check("drop_sat", drop_count, 7);
    wait_not_busy("clr2_done");
    do_read(8'd60, 0);

    // Reset while an increment sits in INC_WR.
    Addr = 8'd200; Memory_add = 1'b1;
    tick();
    tick();
    tick();
    rst_n      = 1'b0;
    Memory_add = 1'b0;
    #1;
    check("midrst_busy", busy,       1);
    check("midrst_drop", drop_count, 0);
    repeat (3) tick();
    @(negedge clk);
    release_and_sweep("midrst");
    for (int a = 0; a < 256; a++) do_read(8'(a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
